// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM encoding, default constants and the MISR/LFSR step function.
package bist_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPACT = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] REPORT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StCompact = COMPACT,
    StCheck   = CHECK,
    StReport  = REPORT
  } state_e;

  localparam logic [15:0] DefaultPoly = 16'h1021;
  localparam logic [15:0] DefaultSeed = 16'hFFFF;

  // Widest register the step function supports; callers zero-extend and truncate.
  localparam int unsigned MaxW = 64;

  function automatic logic [MaxW-1:0] misr_step(input logic [MaxW-1:0] cur,
                                                input logic [MaxW-1:0] poly,
                                                input logic [MaxW-1:0] data,
                                                input int unsigned     w);
    logic [MaxW-1:0] mask;
    logic            msb;
    logic [MaxW-1:0] nxt;
    mask = (64'd1 << w) - 64'd1;
    msb  = |(cur & (64'd1 << (w - 1)));
    nxt  = (cur << 1) ^ (msb ? poly : '0) ^ data;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register; load has priority over a compaction step.
module misr_reg
  import bist_pkg::*;
#(
  parameter int unsigned  W        = 16,
  parameter logic [W-1:0] POLY     = W'(DefaultPoly),
  parameter logic [W-1:0] SEED_VAL = W'(DefaultSeed)
) (
  input  logic         clk,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [W-1:0] value
);

  logic [MaxW-1:0] nxt;
  logic            unused_nxt_hi;

  assign nxt           = misr_step(MaxW'(value), MaxW'(POLY), MaxW'(data), W);
  assign unused_nxt_hi = |(nxt >> W);

  always_ff @(posedge clk) begin
    if (load) begin
      value <= SEED_VAL;
    end else if (enable) begin
      value <= nxt[W-1:0];
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses into a MISR, then compares signature
// and word count against golden values and holds the verdict while bist_end is high.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned  W         = 16,
  parameter logic [W-1:0] POLY      = W'(DefaultPoly),
  parameter logic [W-1:0] SEED_VAL  = W'(DefaultSeed),
  parameter logic [W-1:0] GOLDEN    = '0,
  parameter logic [7:0]   EXP_COUNT = 8'd90
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         running,
  input  logic         seed,
  input  logic         finish,
  input  logic         bist_end,
  input  logic [W-1:0] cut_out,
  output logic [W-1:0] signature,
  output logic [7:0]   pat_count,
  output logic         done,
  output logic         pass,
  output logic         fail
);

  state_e     state_q, state_d;
  logic [7:0] count_q;
  logic       match_q;
  logic       collecting;
  logic       reload;
  logic       step;

  assign collecting = (state_q == StIdle) || (state_q == StCompact);
  // Seed wins over a same-cycle running strobe; leaving REPORT also rearms the MISR.
  assign reload     = (collecting && seed) || ((state_q == StReport) && !bist_end);
  assign step       = collecting && running && !seed;

  misr_reg #(
    .W       (W),
    .POLY    (POLY),
    .SEED_VAL(SEED_VAL)
  ) u_misr (
    .clk   (clk),
    .load  (reset || reload),
    .enable(step),
    .data  (cut_out),
    .value (signature)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (finish) state_d = StCheck;
        else if (step) state_d = StCompact;
      end
      StCompact: begin
        if (finish) state_d = StCheck;
      end
      StCheck:  state_d = StReport;
      StReport: begin
        if (!bist_end) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (reload) begin
        count_q <= '0;
      end else if (step && (count_q != 8'hFF)) begin
        count_q <= count_q + 8'd1;
      end
      if (state_q == StCheck) begin
        match_q <= (signature == GOLDEN) && (count_q == EXP_COUNT);
      end else if (reload) begin
        match_q <= 1'b0;
      end
    end
  end

  assign pat_count = count_q;
  assign done      = (state_q == StReport);
  assign pass      = done && match_q;
  assign fail      = done && !match_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus literal checks.
module tb_bist_response_analyzer;

  localparam int unsigned W         = 4;
  localparam logic [3:0]  POLY      = 4'h3;
  localparam logic [3:0]  SEED_VAL  = 4'h0;
  localparam logic [3:0]  GOLDEN    = 4'h4;
  localparam logic [7:0]  EXP_COUNT = 8'd3;

  logic       clk = 1'b0;
  logic       reset, running, seed, finish, bist_end;
  logic [3:0] cut_out;
  logic [3:0] signature;
  logic [7:0] pat_count;
  logic       done, pass, fail;

  bist_response_analyzer #(
    .W        (W),
    .POLY     (POLY),
    .SEED_VAL (SEED_VAL),
    .GOLDEN   (GOLDEN),
    .EXP_COUNT(EXP_COUNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .running  (running),
    .seed     (seed),
    .finish   (finish),
    .bist_end (bist_end),
    .cut_out  (cut_out),
    .signature(signature),
    .pat_count(pat_count),
    .done     (done),
    .pass     (pass),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: arithmetic signature, saturating count, verdict one cycle after finish.
  int m_sig, m_cnt;
  bit m_pending, m_reporting, m_verdict, m_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_sig = 0; m_cnt = 0; m_pending = 0; m_reporting = 0; m_verdict = 0; m_valid = 1;
    end else if (m_reporting) begin
      if (!bist_end) begin
        m_reporting = 0; m_verdict = 0; m_sig = 0; m_cnt = 0;
      end
    end else if (m_pending) begin
      m_verdict   = (m_sig == 4) && (m_cnt == 3);
      m_pending   = 0;
      m_reporting = 1;
    end else begin
      if (seed) begin
        m_sig = 0; m_cnt = 0;
      end else if (running) begin
        m_sig = ((m_sig * 2) % 16) ^ ((m_sig >= 8) ? 3 : 0) ^ int'(cut_out);
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
      if (finish) m_pending = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("signature", int'(signature), m_sig);
      chk("pat_count", int'(pat_count), m_cnt);
      chk("done", int'(done), int'(m_reporting));
      chk("pass", int'(pass), int'(m_reporting && m_verdict));
      chk("fail", int'(fail), int'(m_reporting && !m_verdict));
    end
  end

  task automatic drive(input bit r, input bit s, input bit f, input logic [3:0] d);
    @(negedge clk);
    running = r; seed = s; finish = f; cut_out = d;
    @(posedge clk);
    #1;
  endtask

  task automatic release_end();
    @(negedge clk);
    running = 0; seed = 0; finish = 0; cut_out = 0; bist_end = 0;
    @(posedge clk);
    #1;
    bist_end = 1;
  endtask

  initial begin
    reset = 1; running = 0; seed = 0; finish = 0; bist_end = 1; cut_out = 0;
    drive(0, 0, 0, 4'h0);
    drive(0, 0, 0, 4'h0);
    chk("rst_sig", int'(signature), 0);
    chk("rst_cnt", int'(pat_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    reset = 0;

    // Golden run 1,2,4 -> signatures 1,0,4 then PASS
    drive(1, 0, 0, 4'h1); chk("a_sig1", int'(signature), 1);
    drive(1, 0, 0, 4'h2); chk("a_sig2", int'(signature), 0);
    drive(1, 0, 0, 4'h4); chk("a_sig3", int'(signature), 4);
    chk("a_cnt", int'(pat_count), 3);
    drive(0, 0, 1, 4'h0); chk("a_done_check", int'(done), 0);
    drive(0, 0, 0, 4'h0); chk("a_done", int'(done), 1); chk("a_pass", int'(pass), 1);
    drive(1, 1, 1, 4'h5); chk("a_hold_sig", int'(signature), 4); chk("a_hold_pass", int'(pass), 1);
    release_end();
    chk("a_rel_done", int'(done), 0); chk("a_rel_sig", int'(signature), 0);
    chk("a_rel_cnt", int'(pat_count), 0);

    // Feedback tap: 8 then 0 -> 8, 3; wrong signature fails
    drive(1, 0, 0, 4'h8); chk("b_sig1", int'(signature), 8);
    drive(1, 0, 0, 4'h0); chk("b_sig2", int'(signature), 3);
    drive(0, 0, 1, 4'h0);
    drive(0, 0, 0, 4'h0); chk("b_fail", int'(fail), 1); chk("b_pass", int'(pass), 0);
    release_end();

    // Right signature, wrong count
    drive(1, 0, 0, 4'h0); drive(1, 0, 0, 4'h1); drive(1, 0, 0, 4'h2); drive(1, 0, 0, 4'h4);
    chk("c_sig", int'(signature), 4); chk("c_cnt", int'(pat_count), 4);
    drive(0, 0, 1, 4'h0);
    drive(0, 0, 0, 4'h0); chk("c_fail", int'(fail), 1);
    release_end();

    // Reseed overrides running
    drive(1, 0, 0, 4'h1); drive(1, 0, 0, 4'h2);
    drive(1, 1, 0, 4'h7); chk("d_seed_sig", int'(signature), 0); chk("d_seed_cnt", int'(pat_count), 0);
    drive(1, 0, 0, 4'h1); drive(1, 0, 0, 4'h2); drive(1, 0, 0, 4'h4);
    drive(0, 0, 1, 4'h0);
    drive(0, 0, 0, 4'h0); chk("d_pass", int'(pass), 1); chk("d_cnt", int'(pat_count), 3);
    release_end();

    // Running and finish together: last word counted
    drive(1, 0, 0, 4'h1); drive(1, 0, 0, 4'h2);
    drive(1, 0, 1, 4'h4); chk("e_sig", int'(signature), 4); chk("e_cnt", int'(pat_count), 3);
    drive(0, 0, 0, 4'h0); chk("e_pass", int'(pass), 1);
    release_end();

    // Finish with nothing compacted
    drive(0, 0, 1, 4'h0);
    drive(0, 0, 0, 4'h0); chk("z_fail", int'(fail), 1);
    release_end();

    // Reset while reporting
    drive(1, 0, 0, 4'h1); drive(1, 0, 0, 4'h2); drive(1, 0, 0, 4'h4);
    drive(0, 0, 1, 4'h0);
    drive(0, 0, 0, 4'h0); chk("f_pass_pre", int'(pass), 1);
    reset = 1;
    drive(0, 0, 0, 4'h0);
    chk("f_done", int'(done), 0); chk("f_pass", int'(pass), 0);
    chk("f_sig", int'(signature), 0); chk("f_cnt", int'(pat_count), 0);
    reset = 0;

    // Counter saturation
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 4'(i));
    chk("g_sat", int'(pat_count), 255);
    drive(0, 0, 0, 4'h0);
    chk("g_sat_hold", int'(pat_count), 255);

    drive(0, 0, 0, 4'h0);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
